// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display controller.
//   cmd_op_t   : keypad/ALU command encoding
//   SEG_BLANK  : active-low pattern with every segment off
//   bcd_to_seg : BCD digit to active-low 7-segment pattern (bit0=a .. bit6=g)
package calc_pkg;

   typedef enum logic [1:0] {
      CMD_WRITE = 2'b00,
      CMD_PUSH  = 2'b01,
      CMD_BKSP  = 2'b10,
      CMD_CLEAR = 2'b11
   } cmd_op_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] seg;
      unique case (d)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/display_scan.sv
// Time-multiplexed scan driver for the digit displays.
//   clock, reset : system clock, synchronous active-high reset
//   seg_in       : N_DIGITS already-blanked active-low patterns
//   an_scan      : one-hot active-low digit select (registered)
//   seg_scan     : pattern of the selected digit (registered)
module display_scan #(
   parameter int unsigned N_DIGITS = 8,
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [N_DIGITS-1:0][6:0]     seg_in,
   output logic [N_DIGITS-1:0]          an_scan,
   output logic [6:0]                   seg_scan
);
   import calc_pkg::*;

   localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = $clog2(N_DIGITS);

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [N_DIGITS-1:0] an_q;
   logic [6:0]          seg_q;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
      if (cnt_q == CW'(SCAN_DIV - 1)) begin
         cnt_d = '0;
         idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
   end

   // Outputs sample the current index and live patterns, so content edits show
   // up on the next cycle without disturbing the slot timing.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
         idx_q <= '0;
         an_q  <= '1;
         seg_q <= SEG_BLANK;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         an_q  <= ~(N_DIGITS'(1) << idx_q);
         seg_q <= seg_in[idx_q];
      end
   end

   assign an_scan  = an_q;
   assign seg_scan = seg_q;

endmodule

// File: rtl/calc_display_ctrl.sv
// N-digit BCD display controller for the calculator.
//   clock, reset       : system clock, synchronous active-high reset
//   cmd_valid/op/pos/dig : one command per cycle (WRITE, PUSH, BACKSPACE, CLEAR)
//   cmd_err            : one-cycle pulse when the previous command was rejected
//   len                : count of significant digits entered via PUSH
//   seg_static         : all digits decoded in parallel, active-low
//   seg_scan, an_scan  : time-multiplexed scan bus
module calc_display_ctrl #(
   parameter int unsigned N_DIGITS = 8,
   parameter int unsigned SCAN_DIV = 1000,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          cmd_valid,
   input  logic [1:0]                    cmd_op,
   input  logic [3:0]                    cmd_pos,
   input  logic [3:0]                    cmd_dig,
   output logic                          cmd_err,
   output logic [$clog2(N_DIGITS+1)-1:0] len,
   output logic [N_DIGITS-1:0][6:0]      seg_static,
   output logic [6:0]                    seg_scan,
   output logic [N_DIGITS-1:0]           an_scan
);
   import calc_pkg::*;

   localparam int unsigned LW = $clog2(N_DIGITS + 1);

   logic [N_DIGITS-1:0][3:0] digit_q, digit_d;
   logic [LW-1:0]            len_q, len_d;
   logic                     err_q, err_d;
   cmd_op_t                  op;

   assign op = cmd_op_t'(cmd_op);

   always_comb begin
      digit_d = digit_q;
      len_d   = len_q;
      err_d   = 1'b0;
      if (cmd_valid) begin
         unique case (op)
            CMD_WRITE: begin
               if (({1'b0, cmd_pos} < 5'(N_DIGITS)) && (cmd_dig < 4'd10)) begin
                  for (int i = 0; i < N_DIGITS; i++) begin
                     if (cmd_pos == 4'(i)) digit_d[i] = cmd_dig;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            CMD_PUSH: begin
               if ((cmd_dig >= 4'd10) || (len_q == LW'(N_DIGITS))) begin
                  err_d = 1'b1;
               end else if (!((len_q == '0) && (cmd_dig == 4'd0))) begin
                  // A zero typed before any significant digit is absorbed.
                  digit_d = {digit_q[N_DIGITS-2:0], cmd_dig};
                  len_d   = len_q + LW'(1);
               end
            end
            CMD_BKSP: begin
               if (len_q != '0) begin
                  digit_d = {4'd0, digit_q[N_DIGITS-1:1]};
                  len_d   = len_q - LW'(1);
               end
            end
            CMD_CLEAR: begin
               digit_d = '0;
               len_d   = '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         digit_q <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         digit_q <= digit_d;
         len_q   <= len_d;
         err_q   <= err_d;
      end
   end

   // Walk from the most significant digit down; a digit is blanked while no
   // nonzero digit has been seen at or above it. Digit 0 always shows.
   always_comb begin
      logic seen;
      seen       = 1'b0;
      seg_static = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         seen = seen | (digit_q[i] != 4'd0);
         if (BLANK_LZ && (i != 0) && !seen) seg_static[i] = SEG_BLANK;
         else                               seg_static[i] = bcd_to_seg(digit_q[i]);
      end
   end

   display_scan #(
      .N_DIGITS (N_DIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clock    (clock),
      .reset    (reset),
      .seg_in   (seg_static),
      .an_scan  (an_scan),
      .seg_scan (seg_scan)
   );

   assign cmd_err = err_q;
   assign len     = len_q;

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Randomised self-checking bench for calc_display_ctrl against a behavioural model.
module tb_calc_display_ctrl;

   localparam int N  = 8;
   localparam int SD = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             cmd_valid = 1'b0;
   logic [1:0]       cmd_op = 2'b00;
   logic [3:0]       cmd_pos = 4'd0;
   logic [3:0]       cmd_dig = 4'd0;
   logic             cmd_err;
   logic [3:0]       len;
   logic [N-1:0][6:0] seg_static;
   logic [6:0]       seg_scan;
   logic [N-1:0]     an_scan;

   calc_display_ctrl #(
      .N_DIGITS (N),
      .SCAN_DIV (SD),
      .BLANK_LZ (1'b1)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_op     (cmd_op),
      .cmd_pos    (cmd_pos),
      .cmd_dig    (cmd_dig),
      .cmd_err    (cmd_err),
      .len        (len),
      .seg_static (seg_static),
      .seg_scan   (seg_scan),
      .an_scan    (an_scan)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;

   // Behavioural model
   logic [6:0]   seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   int           m_dig [N];
   int           m_len;
   logic         m_err;
   logic [N-1:0] m_an;
   logic [6:0]   m_seg;
   int           t_run;
   bit           m_ok = 0;

   function automatic logic [6:0] exp_pat(input int i);
      bit all_zero = 1;
      for (int j = i; j < N; j++) if (m_dig[j] != 0) all_zero = 0;
      if (i > 0 && all_zero) return 7'h7F;
      return seg_tbl[m_dig[i]];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_update();
      int idx;
      if (reset) begin
         for (int i = 0; i < N; i++) m_dig[i] = 0;
         m_len = 0;
         m_err = 0;
         m_an  = '1;
         m_seg = 7'h7F;
         t_run = 0;
      end else begin
         // Scan output reflects the slot and the digits as they were before this edge.
         idx   = (t_run / SD) % N;
         m_an  = ~(N'(1) << idx);
         m_seg = exp_pat(idx);
         t_run++;
         m_err = 0;
         if (cmd_valid) begin
            case (cmd_op)
               2'b00: if (cmd_pos < N && cmd_dig < 10) m_dig[cmd_pos] = cmd_dig;
                      else m_err = 1;
               2'b01: begin
                  if (cmd_dig >= 10 || m_len == N) m_err = 1;
                  else if (!(m_len == 0 && cmd_dig == 0)) begin
                     for (int i = N - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
                     m_dig[0] = cmd_dig;
                     m_len++;
                  end
               end
               2'b10: if (m_len > 0) begin
                  for (int i = 0; i < N - 1; i++) m_dig[i] = m_dig[i+1];
                  m_dig[N-1] = 0;
                  m_len--;
               end
               default: begin
                  for (int i = 0; i < N; i++) m_dig[i] = 0;
                  m_len = 0;
               end
            endcase
         end
      end
      m_ok = 1;
   endtask

   // Entered just after a falling edge; drives, clocks, updates the model,
   // and returns at the next falling edge.
   task automatic cmd(input logic v, input logic [1:0] op, input logic [3:0] pos,
                      input logic [3:0] dig, input logic rst);
      reset     = rst;
      cmd_valid = v;
      cmd_op    = op;
      cmd_pos   = pos;
      cmd_dig   = dig;
      @(posedge clock);
      model_update();
      @(negedge clock);
   endtask

   task automatic idle();
      cmd(1'b0, 2'b00, 4'd0, 4'd0, 1'b0);
   endtask

   always @(negedge clock) begin
      if (m_ok) begin
         check("len", 32'(len), 32'(m_len));
         check("cmd_err", 32'(cmd_err), 32'(m_err));
         check("an_scan", 32'(an_scan), 32'(m_an));
         check("seg_scan", 32'(seg_scan), 32'(m_seg));
         for (int i = 0; i < N; i++)
            check($sformatf("seg_static[%0d]", i), 32'(seg_static[i]), 32'(exp_pat(i)));
      end
   end

   initial begin
      int c_fe, c_fd, c_oth, r;
      logic [3:0] d;
      @(negedge clock);
      cmd(1'b0, 2'b00, 4'd0, 4'd0, 1'b1);
      check("rst an_scan", 32'(an_scan), 32'hFF);
      check("rst seg_scan", 32'(seg_scan), 32'h7F);
      check("rst len", 32'(len), 32'd0);
      check("rst cmd_err", 32'(cmd_err), 32'd0);

      idle();
      check("first an_scan", 32'(an_scan), 32'hFE);
      cmd(1'b1, 2'b01, 4'd0, 4'd1, 1'b0);
      cmd(1'b1, 2'b01, 4'd0, 4'd2, 1'b0);
      cmd(1'b1, 2'b01, 4'd0, 4'd3, 1'b0);
      check("push len", 32'(len), 32'd3);
      check("push seg0", 32'(seg_static[0]), 32'h30);
      check("push seg1", 32'(seg_static[1]), 32'h24);
      check("push seg2", 32'(seg_static[2]), 32'h79);
      for (int i = 3; i < N; i++)
         check($sformatf("push seg%0d blank", i), 32'(seg_static[i]), 32'h7F);

      cmd(1'b1, 2'b11, 4'd0, 4'd0, 1'b0);
      cmd(1'b1, 2'b01, 4'd0, 4'd0, 1'b0);
      check("push0 len", 32'(len), 32'd0);
      check("push0 err", 32'(cmd_err), 32'd0);
      cmd(1'b1, 2'b01, 4'd0, 4'd5, 1'b0);
      check("push5 len", 32'(len), 32'd1);
      check("push5 seg0", 32'(seg_static[0]), 32'h12);

      cmd(1'b1, 2'b11, 4'd0, 4'd0, 1'b0);
      for (int k = 0; k < 9; k++) cmd(1'b1, 2'b01, 4'd0, 4'd9, 1'b0);
      check("full err", 32'(cmd_err), 32'd1);
      check("full len", 32'(len), 32'd8);
      check("full seg7", 32'(seg_static[7]), 32'h10);
      idle();
      check("err pulse", 32'(cmd_err), 32'd0);
      for (int k = 0; k < 9; k++) cmd(1'b1, 2'b10, 4'd0, 4'd0, 1'b0);
      check("bksp len", 32'(len), 32'd0);
      check("bksp seg0", 32'(seg_static[0]), 32'h40);
      check("bksp err", 32'(cmd_err), 32'd0);

      cmd(1'b1, 2'b00, 4'd8, 4'd4, 1'b0);
      check("write pos8 err", 32'(cmd_err), 32'd1);
      cmd(1'b1, 2'b00, 4'd2, 4'd12, 1'b0);
      check("write dig12 err", 32'(cmd_err), 32'd1);
      check("write dig12 seg2", 32'(seg_static[2]), 32'h7F);
      cmd(1'b1, 2'b00, 4'd6, 4'd0, 1'b0);
      check("write zero blank", 32'(seg_static[6]), 32'h7F);

      // Digits 00000031, then 32 idle cycles cover each slot exactly 4 times.
      cmd(1'b1, 2'b11, 4'd0, 4'd0, 1'b0);
      cmd(1'b1, 2'b01, 4'd0, 4'd3, 1'b0);
      cmd(1'b1, 2'b01, 4'd0, 4'd1, 1'b0);
      c_fe = 0; c_fd = 0; c_oth = 0;
      for (int k = 0; k < 32; k++) begin
         idle();
         if (an_scan == 8'hFE && seg_scan == 7'h79) c_fe++;
         else if (an_scan == 8'hFD && seg_scan == 7'h30) c_fd++;
         else if (seg_scan == 7'h7F && $onehot(~an_scan)) c_oth++;
      end
      check("scan FE slots", 32'(c_fe), 32'd4);
      check("scan FD slots", 32'(c_fd), 32'd4);
      check("scan blank slots", 32'(c_oth), 32'd24);

      cmd(1'b1, 2'b01, 4'd0, 4'd7, 1'b1);
      check("midrst an", 32'(an_scan), 32'hFF);
      check("midrst seg", 32'(seg_scan), 32'h7F);
      check("midrst len", 32'(len), 32'd0);
      check("midrst seg0", 32'(seg_static[0]), 32'h40);
      cmd(1'b1, 2'b11, 4'd0, 4'd0, 1'b1);
      idle();
      check("post rst an", 32'(an_scan), 32'hFE);

      for (int k = 0; k < 2000; k++) begin
         r = $urandom_range(0, 9);
         d = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         cmd(r != 9,
             (r < 4) ? 2'b01 : (r < 6) ? 2'b00 : (r < 8) ? 2'b10 : 2'b11,
             4'($urandom_range(0, 15)), d,
             $urandom_range(0, 149) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
